// File: rtl/reset_sequencer.sv
// Staged reset-release controller: holds all stage resets after system reset,
// then releases them in order, waiting for each stage's ack or a timeout.
module reset_sequencer #(
    parameter int NUM_STAGES     = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk_in,
    input  logic                  rst_in_n,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  seq_busy,
    output logic                  seq_done,
    output logic                  timeout_err,
    output logic [((NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1)-1:0] err_stage
);

    localparam int IDX_W   = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam int MAX_A   = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
    localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

    localparam logic [1:0] ST_HOLD     = 2'd0;
    localparam logic [1:0] ST_WAIT_ACK = 2'd1;
    localparam logic [1:0] ST_GAP      = 2'd2;
    localparam logic [1:0] ST_DONE     = 2'd3;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [NUM_STAGES-1:0] r_stage_rst_n;
    logic                  r_seq_busy;
    logic                  r_seq_done;
    logic                  r_timeout_err;
    logic [IDX_W-1:0]      r_err_stage;

    logic [1:0]            w_state_nxt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_ack;
    logic                  w_hold_exp;
    logic                  w_gap_exp;
    logic                  w_stage_end;
    logic                  w_timeout;
    logic                  w_last_stage;

    assign stage_rst_n = r_stage_rst_n;
    assign seq_busy    = r_seq_busy;
    assign seq_done    = r_seq_done;
    assign timeout_err = r_timeout_err;
    assign err_stage   = r_err_stage;

    // Only the current stage's ack bit is observed.
    always_comb begin
        w_ack = 1'b0;
        for (int unsigned i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == r_idx) begin
                w_ack = stage_ack[i];
            end
        end
    end

    // soft_rst_req masks every stage event so it overrides all transitions.
    always_comb begin
        w_next_idx   = r_idx + IDX_W'(1);
        w_last_stage = (r_idx == LAST_IDX);
        w_hold_exp   = !soft_rst_req && (r_state == ST_HOLD) && (r_cnt == STRETCH_LAST);
        w_gap_exp    = !soft_rst_req && (r_state == ST_GAP) && (r_cnt == GAP_LAST);
        w_stage_end  = !soft_rst_req && (r_state == ST_WAIT_ACK) &&
                       (w_ack || (r_cnt == TIMEOUT_LAST));
        w_timeout    = !soft_rst_req && (r_state == ST_WAIT_ACK) && !w_ack &&
                       (r_cnt == TIMEOUT_LAST);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        if (soft_rst_req) begin
            w_state_nxt = ST_HOLD;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (w_hold_exp) begin
                        w_state_nxt = ST_WAIT_ACK;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_WAIT_ACK: begin
                    if (w_stage_end) begin
                        w_state_nxt = w_last_stage ? ST_DONE : ST_GAP;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_GAP: begin
                    if (w_gap_exp) begin
                        w_state_nxt = ST_WAIT_ACK;
                        w_cnt_nxt   = '0;
                    end
                end
                default: begin
                    w_state_nxt = ST_DONE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_idx <= '0;
        end else if (soft_rst_req) begin
            r_idx <= '0;
        end else if (w_gap_exp) begin
            r_idx <= w_next_idx;
        end
    end

    // Released bits are only ever set, so the outputs stay a thermometer code.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_stage_rst_n <= '0;
        end else if (soft_rst_req) begin
            r_stage_rst_n <= '0;
        end else if (w_hold_exp) begin
            r_stage_rst_n[0] <= 1'b1;
        end else if (w_gap_exp) begin
            for (int unsigned i = 0; i < NUM_STAGES; i++) begin
                if (IDX_W'(i) == w_next_idx) begin
                    r_stage_rst_n[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_seq_busy <= 1'b1;
            r_seq_done <= 1'b0;
        end else if (soft_rst_req) begin
            r_seq_busy <= 1'b1;
            r_seq_done <= 1'b0;
        end else if (w_stage_end && w_last_stage) begin
            r_seq_busy <= 1'b0;
            r_seq_done <= 1'b1;
        end
    end

    // Error record survives soft restarts; only the hard reset clears it.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_timeout_err <= 1'b0;
            r_err_stage   <= '0;
        end else if (w_timeout) begin
            r_timeout_err <= 1'b1;
            r_err_stage   <= r_idx;
        end
    end

endmodule
